// File: rtl/pc_fetch_sequencer.sv
// Multicycle fetch controller: owns the PC, runs the imem req/ack handshake, counts retirements.
// Optional `PCSEQ_ALIGN_CHECK_EN: fault on a misaligned NextPC instead of silently aligning it.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic [31:0]      NextPC,
    input  logic             Stall,
    input  logic             ImemAck,
    input  logic [31:0]      ImemData,
    output logic             ImemReq,
    output logic [31:0]      ImemAddr,
    output logic [31:0]      CurrentPC,
    output logic [31:0]      Instr,
    output logic             InstrValid,
    output logic [CNT_W-1:0] RetireCount,
    output logic             Fault
);

    typedef enum logic [1:0] {StBoot, StFetch, StExec, StFault} state_t;

    state_t     state;
    logic [7:0] waitCnt;

    assign ImemAddr = CurrentPC;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= StBoot;
            waitCnt     <= 8'd0;
            CurrentPC   <= RESET_PC;
            Instr       <= 32'h0;
            InstrValid  <= 1'b0;
            ImemReq     <= 1'b0;
            RetireCount <= '0;
            Fault       <= 1'b0;
        end else begin
            unique case (state)
                StBoot: begin
                    state   <= StFetch;
                    ImemReq <= 1'b1;
                end
                StFetch: begin
                    // An ack in the timeout cycle still counts as a successful fetch.
                    if (ImemAck) begin
                        Instr      <= ImemData;
                        waitCnt    <= 8'd0;
                        ImemReq    <= 1'b0;
                        InstrValid <= 1'b1;
                        state      <= StExec;
                    end else if (waitCnt == 8'(TIMEOUT - 1)) begin
                        Fault   <= 1'b1;
                        ImemReq <= 1'b0;
                        state   <= StFault;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                StExec: begin
                    if (!Stall) begin
                        RetireCount <= RetireCount + CNT_W'(1);
                        InstrValid  <= 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
                        if (NextPC[1:0] != 2'b00) begin
                            Fault <= 1'b1;
                            state <= StFault;
                        end else begin
                            CurrentPC <= NextPC;
                            ImemReq   <= 1'b1;
                            state     <= StFetch;
                        end
`else
                        CurrentPC <= NextPC & 32'hFFFF_FFFC;
                        ImemReq   <= 1'b1;
                        state     <= StFetch;
`endif
                    end
                end
                StFault: begin
                    ImemReq    <= 1'b0;
                    InstrValid <= 1'b0;
                end
                default: state <= StFault;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer (RESET_PC=0, TIMEOUT=16, CNT_W=32).
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [31:0] NextPC;
    logic        Stall;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] CurrentPC;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] RetireCount;
    logic        Fault;

    int assertCount = 0;
    int failCount   = 0;

    pc_fetch_sequencer #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (16),
        .CNT_W   (32)
    ) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .NextPC     (NextPC),
        .Stall      (Stall),
        .ImemAck    (ImemAck),
        .ImemData   (ImemData),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .CurrentPC  (CurrentPC),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .RetireCount(RetireCount),
        .Fault      (Fault)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reset, release, and step through BOOT so the DUT sits in its first FETCH cycle.
    task automatic do_reset();
        Reset_L  = 1'b0;
        ImemAck  = 1'b0;
        Stall    = 1'b0;
        NextPC   = 32'h0;
        ImemData = 32'h0;
        tick();
        tick();
        Reset_L = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset_L  = 1'b0;
        ImemAck  = 1'b0;
        Stall    = 1'b0;
        NextPC   = 32'h0;
        ImemData = 32'h0;
        #3;
        tick();
        assertCount++;
        if (ImemReq !== 1'b0 || InstrValid !== 1'b0 || Fault !== 1'b0) begin
            $display("FAIL reset_ctrl req=%b valid=%b fault=%b want 0/0/0", ImemReq, InstrValid, Fault);
            failCount++;
        end
        assertCount++;
        if (CurrentPC !== 32'h0 || Instr !== 32'h0 || RetireCount !== 32'h0) begin
            $display("FAIL reset_regs pc=%h instr=%h cnt=%0d want 0/0/0", CurrentPC, Instr, RetireCount);
            failCount++;
        end
        Reset_L = 1'b1;
        #1;
        assertCount++;
        if (ImemReq !== 1'b0) begin
            $display("FAIL boot_req got %b want 0", ImemReq);
            failCount++;
        end
        tick();
        assertCount++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin
            $display("FAIL first_fetch req=%b addr=%h want 1/00000000", ImemReq, ImemAddr);
            failCount++;
        end
    endtask

    task automatic test_sequential();
        tick();
        ImemAck  = 1'b1;
        ImemData = 32'h2008_0005;
        tick();
        ImemAck  = 1'b0;
        Stall    = 1'b0;
        NextPC   = 32'h0000_0004;
        assertCount++;
        if (InstrValid !== 1'b1 || Instr !== 32'h2008_0005 || ImemReq !== 1'b0) begin
            $display("FAIL seq_exec valid=%b instr=%h req=%b want 1/20080005/0", InstrValid, Instr, ImemReq);
            failCount++;
        end
        assertCount++;
        if (CurrentPC !== 32'h0) begin
            $display("FAIL seq_pc_before got %h want 00000000", CurrentPC);
            failCount++;
        end
        tick();
        assertCount++;
        if (InstrValid !== 1'b0 || CurrentPC !== 32'h4 || RetireCount !== 32'd1) begin
            $display("FAIL seq_advance valid=%b pc=%h cnt=%0d want 0/00000004/1", InstrValid, CurrentPC, RetireCount);
            failCount++;
        end
        assertCount++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin
            $display("FAIL seq_next_fetch req=%b addr=%h want 1/00000004", ImemReq, ImemAddr);
            failCount++;
        end
    endtask

    task automatic test_stall_jump();
        ImemAck  = 1'b1;
        ImemData = 32'h8C01_0000;
        Stall    = 1'b1;
        NextPC   = 32'hDEAD_BEE0;
        tick();
        ImemAck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // A stray ack during EXEC must not disturb Instr.
            ImemAck  = (i == 2);
            ImemData = 32'hFFFF_FFFF;
            tick();
            assertCount++;
            if (InstrValid !== 1'b1 || Instr !== 32'h8C01_0000 || CurrentPC !== 32'h4 ||
                RetireCount !== 32'd1 || ImemReq !== 1'b0) begin
                $display("FAIL stall_hold[%0d] valid=%b instr=%h pc=%h cnt=%0d req=%b want 1/8c010000/00000004/1/0",
                         i, InstrValid, Instr, CurrentPC, RetireCount, ImemReq);
                failCount++;
            end
        end
        ImemAck = 1'b0;
        Stall   = 1'b0;
        NextPC  = 32'h0040_0010;
        tick();
        assertCount++;
        if (ImemAddr !== 32'h0040_0010 || ImemReq !== 1'b1 || RetireCount !== 32'd2) begin
            $display("FAIL jump_target addr=%h req=%b cnt=%0d want 00400010/1/2", ImemAddr, ImemReq, RetireCount);
            failCount++;
        end
    endtask

    task automatic test_ack_at_timeout();
        Stall = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        assertCount++;
        if (Fault !== 1'b0 || ImemReq !== 1'b1) begin
            $display("FAIL pre_timeout fault=%b req=%b want 0/1", Fault, ImemReq);
            failCount++;
        end
        ImemAck  = 1'b1;
        ImemData = 32'h1234_5678;
        tick();
        ImemAck = 1'b0;
        NextPC  = 32'h0000_0006;
        assertCount++;
        if (Fault !== 1'b0 || InstrValid !== 1'b1 || Instr !== 32'h1234_5678) begin
            $display("FAIL ack_wins fault=%b valid=%b instr=%h want 0/1/12345678", Fault, InstrValid, Instr);
            failCount++;
        end
        tick();
`ifdef PCSEQ_ALIGN_CHECK_EN
        assertCount++;
        if (Fault !== 1'b1 || CurrentPC !== 32'h0040_0010 || RetireCount !== 32'd3 || ImemReq !== 1'b0) begin
            $display("FAIL misalign fault=%b pc=%h cnt=%0d req=%b want 1/00400010/3/0", Fault, CurrentPC, RetireCount, ImemReq);
            failCount++;
        end
`else
        assertCount++;
        if (Fault !== 1'b0 || CurrentPC !== 32'h0000_0004 || RetireCount !== 32'd3 || ImemReq !== 1'b1) begin
            $display("FAIL misalign fault=%b pc=%h cnt=%0d req=%b want 0/00000004/3/1", Fault, CurrentPC, RetireCount, ImemReq);
            failCount++;
        end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        assertCount++;
        if (Fault !== 1'b0 || ImemReq !== 1'b1) begin
            $display("FAIL timeout_early fault=%b req=%b want 0/1", Fault, ImemReq);
            failCount++;
        end
        tick();
        assertCount++;
        if (Fault !== 1'b1 || ImemReq !== 1'b0) begin
            $display("FAIL timeout_fault fault=%b req=%b want 1/0", Fault, ImemReq);
            failCount++;
        end
        ImemAck  = 1'b1;
        ImemData = 32'hFFFF_FFFF;
        tick();
        ImemAck = 1'b0;
        tick();
        tick();
        assertCount++;
        if (Instr !== 32'h0 || InstrValid !== 1'b0 || Fault !== 1'b1 || CurrentPC !== 32'h0 || ImemReq !== 1'b0) begin
            $display("FAIL late_ack instr=%h valid=%b fault=%b pc=%h req=%b want 00000000/0/1/00000000/0",
                     Instr, InstrValid, Fault, CurrentPC, ImemReq);
            failCount++;
        end
        Reset_L = 1'b0;
        #1;
        assertCount++;
        if (Fault !== 1'b0) begin
            $display("FAIL reset_clears_fault got %b want 0", Fault);
            failCount++;
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        ImemAck  = 1'b1;
        ImemData = 32'hABCD_0001;
        tick();
        ImemAck = 1'b0;
        NextPC  = 32'h0000_0008;
        tick();
        tick();
        assertCount++;
        if (ImemReq !== 1'b1 || CurrentPC !== 32'h8) begin
            $display("FAIL mid_setup req=%b pc=%h want 1/00000008", ImemReq, CurrentPC);
            failCount++;
        end
        // Assert reset between edges with an ack pending; outputs must drop before the next edge.
        ImemAck  = 1'b1;
        ImemData = 32'h5555_AAAA;
        Reset_L  = 1'b0;
        #2;
        assertCount++;
        if (ImemReq !== 1'b0 || CurrentPC !== 32'h0 || RetireCount !== 32'd0 || Instr !== 32'h0) begin
            $display("FAIL async_reset req=%b pc=%h cnt=%0d instr=%h want 0/00000000/0/00000000",
                     ImemReq, CurrentPC, RetireCount, Instr);
            failCount++;
        end
        tick();
        ImemAck = 1'b0;
        Reset_L = 1'b1;
        tick();
        assertCount++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || Instr !== 32'h0 || InstrValid !== 1'b0) begin
            $display("FAIL restart_fetch req=%b addr=%h instr=%h valid=%b want 1/00000000/00000000/0",
                     ImemReq, ImemAddr, Instr, InstrValid);
            failCount++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_jump();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
